// File: rtl/avalon_axi_lite_master_if.sv
// ---------------------------------------------------------------------------
// avalon_axi_lite_master_if
// Bundles the Avalon-MM slave-side signals and the AXI4-Lite master-side
// channels of the Avalon-to-AXI-Lite bridge.
//   master modport : bridge view (takes Avalon requests, drives AXI requests)
//   slave  modport : environment view (Avalon host plus AXI interconnect)
// Avalon : iAvsAddress/Byteenable/Read/Write/Writedata in,
//          oAvsReaddata/Waitrequest/Response, oErrSticky out
// AXI    : AW, W, B, AR, R channels of AXI4-Lite
// ---------------------------------------------------------------------------
interface avalon_axi_lite_master_if #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32
);
   // Avalon-MM side
   logic [31:0]                     iAvsAddress;
   logic [3:0]                      iAvsByteenable;
   logic                            iAvsRead;
   logic                            iAvsWrite;
   logic [31:0]                     iAvsWritedata;
   logic [31:0]                     oAvsReaddata;
   logic                            oAvsWaitrequest;
   logic [1:0]                      oAvsResponse;
   logic                            oErrSticky;
   // AXI4-Lite write address / data / response
   logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
   logic [2:0]                      M_AXI_AWPROT;
   logic                            M_AXI_AWVALID;
   logic                            M_AXI_AWREADY;
   logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
   logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
   logic                            M_AXI_WVALID;
   logic                            M_AXI_WREADY;
   logic [1:0]                      M_AXI_BRESP;
   logic                            M_AXI_BVALID;
   logic                            M_AXI_BREADY;
   // AXI4-Lite read address / data
   logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
   logic [2:0]                      M_AXI_ARPROT;
   logic                            M_AXI_ARVALID;
   logic                            M_AXI_ARREADY;
   logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
   logic [1:0]                      M_AXI_RRESP;
   logic                            M_AXI_RVALID;
   logic                            M_AXI_RREADY;

   modport master (
      input  iAvsAddress, iAvsByteenable, iAvsRead, iAvsWrite, iAvsWritedata,
      output oAvsReaddata, oAvsWaitrequest, oAvsResponse, oErrSticky,
      output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      input  M_AXI_WREADY,
      input  M_AXI_BRESP, M_AXI_BVALID,
      output M_AXI_BREADY,
      output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
      input  M_AXI_ARREADY,
      input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      output M_AXI_RREADY
   );

   modport slave (
      output iAvsAddress, iAvsByteenable, iAvsRead, iAvsWrite, iAvsWritedata,
      input  oAvsReaddata, oAvsWaitrequest, oAvsResponse, oErrSticky,
      input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
      output M_AXI_WREADY,
      output M_AXI_BRESP, M_AXI_BVALID,
      input  M_AXI_BREADY,
      input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
      output M_AXI_ARREADY,
      output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
      input  M_AXI_RREADY
   );
endinterface

// File: rtl/avalon_axi_lite_master.sv
// ---------------------------------------------------------------------------
// avalon_axi_lite_master
// Bridges single 32-bit Avalon-MM read/write requests (waitrequest flow
// control) onto AXI4-Lite, one transaction outstanding at a time.
// Ports:
//   ACLK    : clock, rising edge
//   ARESETN : synchronous active-low reset
//   bus     : avalon_axi_lite_master_if.master (Avalon slave + AXI master)
// Every output comes straight from a flop; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module avalon_axi_lite_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   avalon_axi_lite_master_if.master  bus
);
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

   state_t          state_q, state_d;
   logic            awvalid_q, awvalid_d;
   logic            wvalid_q, wvalid_d;
   logic            bready_q, bready_d;
   logic            arvalid_q, arvalid_d;
   logic            rready_q, rready_d;
   logic [AW-1:0]   awaddr_q, awaddr_d;
   logic [AW-1:0]   araddr_q, araddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW/8-1:0] wstrb_q, wstrb_d;
   logic [DW-1:0]   readdata_q, readdata_d;
   logic [1:0]      resp_q, resp_d;
   logic            waitreq_q, waitreq_d;
   logic            err_q, err_d;

   // Word-align the Avalon byte address, then truncate or zero-extend it.
   function automatic logic [AW-1:0] axi_addr(input logic [31:0] a);
      logic [31:0]   m;
      logic [AW-1:0] r;
      m = {a[31:2], 2'b00};
      for (int i = 0; i < AW; i++) r[i] = (i < 32) ? m[i] : 1'b0;
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      awvalid_d  = awvalid_q;
      wvalid_d   = wvalid_q;
      bready_d   = bready_q;
      arvalid_d  = arvalid_q;
      rready_d   = rready_q;
      awaddr_d   = awaddr_q;
      araddr_d   = araddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      readdata_d = readdata_q;
      resp_d     = resp_q;
      waitreq_d  = waitreq_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            // Write has priority; a concurrent read is picked up later only
            // if the host is still presenting it.
            if (bus.iAvsWrite) begin
               awaddr_d  = axi_addr(bus.iAvsAddress);
               wdata_d   = bus.iAvsWritedata;
               wstrb_d   = bus.iAvsByteenable;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = WR_REQ;
            end else if (bus.iAvsRead) begin
               araddr_d  = axi_addr(bus.iAvsAddress);
               arvalid_d = 1'b1;
               state_d   = RD_REQ;
            end
         end
         WR_REQ: begin
            // AW and W complete independently; a dropped VALID stays low.
            awvalid_d = awvalid_q & ~bus.M_AXI_AWREADY;
            wvalid_d  = wvalid_q & ~bus.M_AXI_WREADY;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (bus.M_AXI_BVALID) begin
               bready_d  = 1'b0;
               resp_d    = bus.M_AXI_BRESP;
               err_d     = err_q | (bus.M_AXI_BRESP != 2'b00);
               waitreq_d = 1'b0;
               state_d   = DONE;
            end
         end
         RD_REQ: begin
            if (bus.M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_RESP;
            end
         end
         RD_RESP: begin
            if (bus.M_AXI_RVALID) begin
               rready_d   = 1'b0;
               readdata_d = bus.M_AXI_RDATA;
               resp_d     = bus.M_AXI_RRESP;
               err_d      = err_q | (bus.M_AXI_RRESP != 2'b00);
               waitreq_d  = 1'b0;
               state_d    = DONE;
            end
         end
         DONE: begin
            waitreq_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q    <= IDLE;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         awaddr_q   <= '0;
         araddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         readdata_q <= '0;
         resp_q     <= 2'b00;
         waitreq_q  <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         bready_q   <= bready_d;
         arvalid_q  <= arvalid_d;
         rready_q   <= rready_d;
         awaddr_q   <= awaddr_d;
         araddr_q   <= araddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         readdata_q <= readdata_d;
         resp_q     <= resp_d;
         waitreq_q  <= waitreq_d;
         err_q      <= err_d;
      end
   end

   assign bus.oAvsReaddata    = readdata_q;
   assign bus.oAvsWaitrequest = waitreq_q;
   assign bus.oAvsResponse    = resp_q;
   assign bus.oErrSticky      = err_q;
   assign bus.M_AXI_AWADDR    = awaddr_q;
   assign bus.M_AXI_AWPROT    = 3'b000;
   assign bus.M_AXI_AWVALID   = awvalid_q;
   assign bus.M_AXI_WDATA     = wdata_q;
   assign bus.M_AXI_WSTRB     = wstrb_q;
   assign bus.M_AXI_WVALID    = wvalid_q;
   assign bus.M_AXI_BREADY    = bready_q;
   assign bus.M_AXI_ARADDR    = araddr_q;
   assign bus.M_AXI_ARPROT    = 3'b000;
   assign bus.M_AXI_ARVALID   = arvalid_q;
   assign bus.M_AXI_RREADY    = rready_q;
endmodule
